// File: rtl/layer_sequencer_if.sv
// Sequencer-side bundle: descriptor writes, sequence control, engine config and handshake.
// The DUT binds to the slave modport; the controller/engine side uses master.
interface layer_sequencer_if #(
  parameter int MAX_LAYERS = 8
);
  localparam int LW = $clog2(MAX_LAYERS);

  logic          cfg_we;
  logic [LW-1:0] cfg_layer;
  logic          cfg_field;
  logic [31:0]   cfg_wdata;
  logic [3:0]    num_layers;
  logic [23:0]   buf_a_base;
  logic [23:0]   buf_b_base;
  logic          seq_start;
  logic          seq_abort;
  logic [7:0]    width;
  logic [7:0]    height;
  logic [10:0]   input_channel;
  logic          stride;
  logic [23:0]   Input_addr_initial;
  logic [23:0]   Weight_addr_initial;
  logic [23:0]   Output_addr_initial;
  logic          Dep_start;
  logic          Dep_finish;
  logic          seq_busy;
  logic          seq_done;
  logic          seq_aborted;
  logic          seq_error;
  logic [LW-1:0] cur_layer;

  modport master (
    output cfg_we, cfg_layer, cfg_field, cfg_wdata, num_layers, buf_a_base, buf_b_base,
           seq_start, seq_abort, Dep_finish,
    input  width, height, input_channel, stride, Input_addr_initial, Weight_addr_initial,
           Output_addr_initial, Dep_start, seq_busy, seq_done, seq_aborted, seq_error, cur_layer
  );

  modport slave (
    input  cfg_we, cfg_layer, cfg_field, cfg_wdata, num_layers, buf_a_base, buf_b_base,
           seq_start, seq_abort, Dep_finish,
    output width, height, input_channel, stride, Input_addr_initial, Weight_addr_initial,
           Output_addr_initial, Dep_start, seq_busy, seq_done, seq_aborted, seq_error, cur_layer
  );
endinterface

// File: rtl/layer_sequencer.sv
// Walks a descriptor table layer by layer, driving the depthwise engine handshake with ping-pong buffers.
// Optional RUN watchdog enabled by defining LAYER_SEQUENCER_WATCHDOG_EN.
module layer_sequencer #(
  parameter int          MAX_LAYERS = 8,
  parameter logic [23:0] WDT_LIMIT  = 24'hFFFFFF
) (
  input logic              CLOCK_50MHZ,
  input logic              RESET,
  layer_sequencer_if.slave bus
);
  // state   | meaning
  // IDLE    | waiting for seq_start, descriptor writes allowed
  // LOAD    | config outputs hold the current slot, engine not yet started
  // RUN     | Dep_start high, waiting for Dep_finish
  // RELEASE | Dep_start low, waiting for Dep_finish to drop
  // NEXT    | decide between next layer and termination
  localparam int LW = $clog2(MAX_LAYERS);
  localparam int NW = (LW + 1 > 4) ? LW + 1 : 4;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_RELEASE, S_NEXT} state_t;
  state_t r_state, w_state_nxt;

  logic [27:0]   r_desc0 [MAX_LAYERS];
  logic [23:0]   r_desc1 [MAX_LAYERS];
  logic [LW-1:0] r_cur_layer, w_load_idx;
  logic [NW-1:0] r_num, w_num;
  logic [27:0]   w_d0;
  logic [23:0]   w_d1;
  logic          r_abort_req, w_abort, w_last, w_we, w_start, w_wdt_trip;
  logic          r_dep_start, r_busy, r_done, r_aborted;
  logic [7:0]    r_width, r_height;
  logic [10:0]   r_ich;
  logic          r_stride;
  logic [23:0]   r_in_addr, r_w_addr, r_out_addr;
  logic          w_unused_wdata;

  assign w_num   = (NW'(bus.num_layers) > NW'(MAX_LAYERS)) ? NW'(MAX_LAYERS) : NW'(bus.num_layers);
  assign w_last  = (NW'(r_cur_layer) + NW'(1)) >= r_num;
  assign w_start = (r_state == S_IDLE) && bus.seq_start;
  assign w_abort = r_abort_req || bus.seq_abort;
  assign w_we    = bus.cfg_we && !r_busy;
  assign w_unused_wdata = ^bus.cfg_wdata[31:28];

  // A write landing on the same edge as the start must reach the first LOAD, hence the bypass.
  assign w_load_idx = (r_state == S_IDLE) ? '0 : r_cur_layer + LW'(1);
  assign w_d0 = (w_we && !bus.cfg_field && bus.cfg_layer == w_load_idx) ?
                bus.cfg_wdata[27:0] : r_desc0[w_load_idx];
  assign w_d1 = (w_we && bus.cfg_field && bus.cfg_layer == w_load_idx) ?
                bus.cfg_wdata[23:0] : r_desc1[w_load_idx];

  always_ff @(posedge CLOCK_50MHZ or posedge RESET) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (bus.seq_start && w_num != '0) w_state_nxt = S_LOAD;
      S_LOAD:    w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_wdt_trip)          w_state_nxt = S_IDLE;
        else if (bus.Dep_finish) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: if (!bus.Dep_finish) w_state_nxt = S_NEXT;
      S_NEXT:    w_state_nxt = (w_last || w_abort) ? S_IDLE : S_LOAD;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50MHZ or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        r_desc0[i] <= '0;
        r_desc1[i] <= '0;
      end
    end else if (w_we) begin
      if (!bus.cfg_field) r_desc0[bus.cfg_layer] <= bus.cfg_wdata[27:0];
      else                r_desc1[bus.cfg_layer] <= bus.cfg_wdata[23:0];
    end
  end

  always_ff @(posedge CLOCK_50MHZ or posedge RESET) begin
    if (RESET) begin
      r_width     <= '0;
      r_height    <= '0;
      r_ich       <= '0;
      r_stride    <= 1'b0;
      r_in_addr   <= '0;
      r_w_addr    <= '0;
      r_out_addr  <= '0;
      r_cur_layer <= '0;
      r_num       <= '0;
      r_dep_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_abort_req <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      if (w_state_nxt == S_LOAD) begin
        r_width    <= w_d0[7:0];
        r_height   <= w_d0[15:8];
        r_ich      <= w_d0[26:16];
        r_stride   <= w_d0[27];
        r_w_addr   <= w_d1;
        r_in_addr  <= w_load_idx[0] ? bus.buf_b_base : bus.buf_a_base;
        r_out_addr <= w_load_idx[0] ? bus.buf_a_base : bus.buf_b_base;
      end
      if (w_start) begin
        r_cur_layer <= '0;
        r_num       <= w_num;
      end else if (r_state == S_NEXT && w_state_nxt == S_LOAD) begin
        r_cur_layer <= w_load_idx;
      end
      r_dep_start <= (w_state_nxt == S_RUN);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (r_state != S_IDLE && w_state_nxt == S_IDLE) || (w_start && w_num == '0);
      if (w_start)                                    r_abort_req <= 1'b0;
      else if (r_state != S_IDLE && bus.seq_abort)    r_abort_req <= 1'b1;
      if (w_start)                                    r_aborted   <= 1'b0;
      else if (r_state == S_NEXT && w_state_nxt == S_IDLE && w_abort) r_aborted <= 1'b1;
    end
  end

`ifdef LAYER_SEQUENCER_WATCHDOG_EN
  logic [23:0] r_wdt;
  logic        r_error;

  // RUN lasting WDT_LIMIT cycles without Dep_finish terminates the sequence.
  assign w_wdt_trip = (r_state == S_RUN) && (r_wdt == WDT_LIMIT - 24'd1);

  always_ff @(posedge CLOCK_50MHZ or posedge RESET) begin
    if (RESET) begin
      r_wdt   <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_LOAD)     r_wdt <= '0;
      else if (r_state == S_RUN) r_wdt <= r_wdt + 24'd1;
      if (w_start)         r_error <= 1'b0;
      else if (w_wdt_trip) r_error <= 1'b1;
    end
  end

  assign bus.seq_error = r_error;
`else
  logic w_unused_wdt;
  assign w_unused_wdt  = ^WDT_LIMIT;
  assign w_wdt_trip    = 1'b0;
  assign bus.seq_error = 1'b0;
`endif

  assign bus.width               = r_width;
  assign bus.height              = r_height;
  assign bus.input_channel       = r_ich;
  assign bus.stride              = r_stride;
  assign bus.Input_addr_initial  = r_in_addr;
  assign bus.Weight_addr_initial = r_w_addr;
  assign bus.Output_addr_initial = r_out_addr;
  assign bus.Dep_start           = r_dep_start;
  assign bus.seq_busy            = r_busy;
  assign bus.seq_done            = r_done;
  assign bus.seq_aborted         = r_aborted;
  assign bus.cur_layer           = r_cur_layer;
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter MAX_LAYERS, default 8, meaning number of descriptor slots (power of 2).
REQ-002 SHALL have parameter WDT_LIMIT, default 24'hFFFFFF, meaning watchdog timeout in cycles.
REQ-003 SHALL have port CLOCK_50MHZ  in  1  sole clock, all state rising-edge.
REQ-004 SHALL have port RESET  in  1  asynchronous active-high reset.
REQ-005 SHALL have ports cfg_we in 1, cfg_layer in log2(MAX_LAYERS), cfg_field in 1, cfg_wdata in 32: descriptor write port.
REQ-006 SHALL have ports num_layers in 4, buf_a_base in 24, buf_b_base in 24: sequence length and ping-pong feature-map bases.
REQ-007 SHALL have ports seq_start in 1 (pulse) and seq_abort in 1 (pulse).
REQ-008 SHALL have outputs width out 8, height out 8, input_channel out 11, stride out 1, Input_addr_initial out 24, Weight_addr_initial out 24, Output_addr_initial out 24, all registered.
REQ-009 SHALL have Dep_start out 1 and Dep_finish in 1, the handshake to the depthwise engine.
REQ-010 SHALL have status outputs seq_busy 1, seq_done 1 (pulse), seq_aborted 1, seq_error 1, cur_layer log2(MAX_LAYERS).

Function
REQ-011 Descriptor field 0 SHALL hold width[7:0], height[15:8], input_channel[26:16], stride[27]; field 1 SHALL hold weight address [23:0].
REQ-012 cfg_we SHALL write cfg_wdata into slot cfg_layer/cfg_field on the same edge when seq_busy=0; writes while seq_busy=1 SHALL be ignored.
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, RELEASE, NEXT.
REQ-014 IDLE: seq_start sampled high with num_layers>0 -> LOAD, cur_layer=0, seq_busy=1, seq_aborted=0, seq_error=0.
REQ-015 IDLE: seq_start with num_layers=0 -> seq_done pulses next cycle, Dep_start never asserted.
REQ-016 LOAD (1 cycle): engine configuration outputs SHALL update from slot cur_layer; -> RUN, Dep_start rising one cycle after outputs change.
REQ-017 Even cur_layer: Input_addr_initial=buf_a_base, Output_addr_initial=buf_b_base; odd: swapped.
REQ-018 RUN: Dep_start=1 held until Dep_finish sampled high -> RELEASE.
REQ-019 RELEASE: Dep_start=0; wait until Dep_finish sampled low -> NEXT.
REQ-020 NEXT (1 cycle): if cur_layer=num_layers-1 or abort latched -> IDLE with seq_done pulse 1 cycle, seq_busy=0; else cur_layer+1 -> LOAD.
REQ-021 seq_abort SHALL latch while busy; layer in flight completes normally; seq_aborted=1 at termination, held until next seq_start.
REQ-022 seq_start while seq_busy=1 SHALL be ignored; seq_abort in IDLE SHALL be ignored.
REQ-023 seq_start and cfg_we on same IDLE edge: the write SHALL be visible to LOAD.
REQ-024 Configuration outputs SHALL remain stable from LOAD until next LOAD.
REQ-025 num_layers>MAX_LAYERS SHALL be clamped to MAX_LAYERS.

Reset
REQ-026 RESET high SHALL asynchronously force IDLE, Dep_start=0, all config outputs 0, seq_busy/seq_done/seq_aborted/seq_error=0, cur_layer=0, watchdog 0.
REQ-027 Descriptor slots SHALL reset to 0.
REQ-028 Reset mid-RUN SHALL drop Dep_start immediately; no seq_done pulse.

Configuration
REQ-029 Macro LAYER_SEQUENCER_WATCHDOG_EN defined: counter clears on LOAD, increments each RUN cycle; reaching WDT_LIMIT -> seq_error=1, Dep_start=0, IDLE, seq_done pulse, seq_busy=0.
REQ-030 Macro undefined: no counter logic, seq_error tied 0, RUN waits indefinitely.

Verification
REQ-031 Write 2 descriptors (32x32x16 s0; 16x16x32 s1), num_layers=2, start, model finish 50 cycles after Dep_start -> two Dep_start pulses, layer0 in=A out=B, layer1 in=B out=A, one seq_done.
REQ-032 num_layers=0, seq_start -> seq_done next cycle, Dep_start stays 0.
REQ-033 num_layers=4, seq_abort during layer 1 RUN -> layer 1 completes, no layer 2 Dep_start, seq_done + seq_aborted=1.
REQ-034 cfg_we during RUN to slot 0 with 0xFFFFFFFF -> slot unchanged; rerun shows original values.
REQ-035 With LAYER_SEQUENCER_WATCHDOG_EN, WDT_LIMIT=100, Dep_finish never high -> seq_error=1 at cycle 100 of RUN, Dep_start low.
REQ-036 RESET pulse mid-RUN -> Dep_start low same cycle asynchronously, outputs 0, no seq_done.
